mult_arbiter: RTL

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter_if.sv | 29 ++
 rtl/mult_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/mult_arbiter_if.sv
// Bundle shared by the requesters, the external multiplier and the arbiter.
// slave is the arbiter's view; master is the requester/multiplier side.
interface mult_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int WIDTHA = 16,
    parameter int WIDTHB = 24
);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*WIDTHA-1:0]   req_a;
    logic [NREQ*WIDTHB-1:0]   req_b;
    logic [WIDTHA-1:0]        mul_a;
    logic [WIDTHB-1:0]        mul_b;
    logic [WIDTHA+WIDTHB-1:0] mul_res;
    logic [NREQ-1:0]          res_valid;
    logic [WIDTHA+WIDTHB-1:0] res_data;
    logic [3:0]               inflight;
    logic                     idle;

    modport slave (
        input  req_valid, req_a, req_b, mul_res,
        output req_ready, mul_a, mul_b, res_valid, res_data, inflight, idle
    );

    modport master (
        output req_valid, req_a, req_b, mul_res,
        input  req_ready, mul_a, mul_b, res_valid, res_data, inflight, idle
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one fixed-latency unsigned multiplier among NREQ
// requesters; an issue-tag pipeline routes each product back to its requester.
module mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTHA  = 16,
    parameter int WIDTHB  = 24,
    parameter int MUL_LAT = 5
) (
    input  logic         clk,
    input  logic         rst,
    mult_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]    r_ptr;
    logic [WIDTHA-1:0] r_mul_a;
    logic [WIDTHB-1:0] r_mul_b;
    logic [MUL_LAT:0]  r_tag_vld;
    logic [IDW-1:0]    r_tag_id [MUL_LAT+1];
    logic [3:0]        r_inflight;

    logic [NREQ-1:0]   w_rot;
    logic [IDW:0]      w_first;
    logic [IDW:0]      w_sum;
    logic [IDW-1:0]    w_grant_id;
    logic              w_xfer;
    logic              w_ret;

    // Rotate requests so bit 0 is the pointer position; lowest set bit wins.
    always_comb begin
        w_rot   = NREQ'({bus.req_valid, bus.req_valid} >> r_ptr);
        w_xfer  = 1'b0;
        w_first = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_xfer  = 1'b1;
                w_first = (IDW+1)'(k);
            end
        end
        w_sum = {1'b0, r_ptr} + w_first;
        if (w_sum >= (IDW+1)'(NREQ)) begin
            w_sum = w_sum - (IDW+1)'(NREQ);
        end
        w_grant_id = IDW'(w_sum);
        if (rst) begin
            w_xfer = 1'b0;
        end
    end

    assign w_ret         = r_tag_vld[MUL_LAT];
    assign bus.req_ready = w_xfer ? (NREQ'(1) << w_grant_id) : '0;
    assign bus.res_valid = w_ret ? (NREQ'(1) << r_tag_id[MUL_LAT]) : '0;
    assign bus.res_data  = bus.mul_res;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;
    assign bus.inflight  = r_inflight;
    assign bus.idle      = (r_inflight == 4'd0) && (bus.req_valid == '0);

    // Issue stage: pointer advance and operand capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
        end else if (w_xfer) begin
            r_ptr   <= (w_grant_id == IDW'(NREQ - 1)) ? '0 : w_grant_id + 1'b1;
            r_mul_a <= bus.req_a[w_grant_id*WIDTHA +: WIDTHA];
            r_mul_b <= bus.req_b[w_grant_id*WIDTHB +: WIDTHB];
        end
    end

    // Tag pipeline: valid is control (reset), id is data (no reset needed)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_vld <= '0;
        end else begin
            r_tag_vld <= {r_tag_vld[MUL_LAT-1:0], w_xfer};
        end
    end

    always_ff @(posedge clk) begin
        r_tag_id[0] <= w_grant_id;
        for (int k = 1; k <= MUL_LAT; k++) begin
            r_tag_id[k] <= r_tag_id[k-1];
        end
    end

    // Occupancy: issue and return in the same cycle cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 4'd0;
        end else begin
            case ({w_xfer, w_ret})
                2'b10:   r_inflight <= r_inflight + 4'd1;
                2'b01:   r_inflight <= r_inflight - 4'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end
endmodule
